// File: rtl/ntt_pkg.sv
// Shared constants and types for the n=512, p=32 NTT datapath control.
// Both stage_sequencer and testbench-side users import this package.
package ntt_pkg;

  localparam int N          = 512;
  localparam int P          = 32;
  localparam int NUM_STAGES = 9;
  localparam int WORDS      = N / P;
  localparam int PIPE_LAT   = 20;

  typedef logic [3:0] stage_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } seq_state_e;

  // Even stages read bank A and write bank B; odd stages swap.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/ntt_stage_sequencer.sv
// Stage-level controller: restarts the 64-cycle stage counter once per stage and
// decodes each count into coefficient RAM strobes, ping-pong banks and twiddle addresses.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int NUM_STAGES = ntt_pkg::NUM_STAGES,
  parameter int WORDS      = ntt_pkg::WORDS,
  parameter int PIPE_LAT   = ntt_pkg::PIPE_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_start,
  input  logic [5:0] cnt_in,
  output logic       cnt_start,
  output logic [3:0] stage_out,
  output logic       rd_en,
  output logic [3:0] rd_addr,
  output logic       rd_bank,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic       wr_bank,
  output logic [7:0] tw_addr,
  output logic       busy,
  output logic       done
);

  // The write window must close before the counter's last value.
  if (PIPE_LAT + WORDS > 63) begin : g_bad_latency
    $error("ntt_stage_sequencer: PIPE_LAT + WORDS must not exceed 63");
  end

  localparam logic [3:0] PIPE_LAT_LO = PIPE_LAT[3:0];

  seq_state_e state, state_next;
  stage_t     stage;
  logic       last_count;
  logic       last_stage;
  logic       rd_hit;
  logic       wr_hit;

  assign last_count = (cnt_in == 6'd63);
  assign last_stage = (int'(stage) >= NUM_STAGES - 1);
  assign rd_hit     = (int'(cnt_in) < WORDS);
  assign wr_hit     = (int'(cnt_in) >= PIPE_LAT) && (int'(cnt_in) < PIPE_LAT + WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_start  = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) state_next = ARM;
      end
      ARM: begin
        cnt_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // Restart beats wrap in the counter, so the next stage follows with no gap.
        if (last_count) begin
          if (last_stage) state_next = FIN;
          else            cnt_start  = 1'b1;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (state == ARM) begin
      stage <= '0;
    end else if (state == RUN && last_count && !last_stage) begin
      stage <= stage + 4'd1;
    end
  end

  // Decode of the current count; outputs lag cnt_in by one cycle and idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_out <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_bank   <= 1'b0;
      tw_addr   <= '0;
    end else if (state == RUN) begin
      stage_out <= stage;
      rd_en     <= rd_hit;
      rd_addr   <= cnt_in[3:0];
      rd_bank   <= stage[0] ? BANK_B : BANK_A;
      wr_en     <= wr_hit;
      wr_addr   <= cnt_in[3:0] - PIPE_LAT_LO;
      wr_bank   <= stage[0] ? BANK_A : BANK_B;
      tw_addr   <= rd_hit ? {stage, cnt_in[3:0]} : 8'h00;
    end else begin
      stage_out <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_bank   <= 1'b0;
      tw_addr   <= '0;
    end
  end

  assign busy = (state == ARM) || (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: stage counter model, cycle-indexed reference
// model, decode table, and directed start/reset/back-to-back sequences.
module tb_ntt_stage_sequencer;

  localparam int NS    = 9;
  localparam int W     = 16;
  localparam int TDONE = 2 + NS * 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_start = 1'b0;
  logic [5:0] cnt = 6'd0;

  logic       cnt_start, rd_en, rd_bank, wr_en, wr_bank, busy, done;
  logic [3:0] stage_out, rd_addr, wr_addr;
  logic [7:0] tw_addr;
  logic       cnt_start_b, rd_en_b, rd_bank_b, wr_en_b, wr_bank_b, busy_b, done_b;
  logic [3:0] stage_out_b, rd_addr_b, wr_addr_b;
  logic [7:0] tw_addr_b;

  ntt_stage_sequencer dut (
    .clk(clk), .rst(rst), .in_start(in_start), .cnt_in(cnt), .cnt_start(cnt_start),
    .stage_out(stage_out), .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .tw_addr(tw_addr),
    .busy(busy), .done(done)
  );

  // Longest legal write latency; shares the counter since restart timing is independent of it.
  ntt_stage_sequencer #(.PIPE_LAT(47)) dut47 (
    .clk(clk), .rst(rst), .in_start(in_start), .cnt_in(cnt), .cnt_start(cnt_start_b),
    .stage_out(stage_out_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_bank(rd_bank_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_bank(wr_bank_b), .tw_addr(tw_addr_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Stage counter: free-running modulo 64, start has priority over wrap.
  always @(posedge clk) cnt <= cnt_start ? 6'd0 : cnt + 6'd1;

  wire [26:0] obs_a = {cnt_start, busy, done, stage_out, rd_en, rd_addr, rd_bank,
                       wr_en, wr_addr, wr_bank, tw_addr};
  wire [26:0] obs_b = {cnt_start_b, busy_b, done_b, stage_out_b, rd_en_b, rd_addr_b,
                       rd_bank_b, wr_en_b, wr_addr_b, wr_bank_b, tw_addr_b};

  int          n_checks = 0;
  int          n_fail = 0;
  int          mt = -1;
  logic        rec = 1'b0;
  int          n_cs = 0;
  int          n_done = 0;
  logic [23:0] snap [0:TDONE];

  typedef struct {
    int          stage;
    int          c;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [23:0] pack_dec(int s, logic re, int ra, logic rb, logic we,
                                           int wa, logic wb, int tw);
    return {4'(s), re, 4'(ra), rb, we, 4'(wa), wb, 8'(tw)};
  endfunction

  // Expected outputs t cycles after the start request was sampled (t<1: idle).
  function automatic logic [26:0] expect_out(int t, int pl);
    logic cs, b, d;
    logic [23:0] dec;
    int c, s;
    cs = 1'b0; b = 1'b0; d = 1'b0; dec = '0;
    if (t >= 1) begin
      b  = (t <= TDONE - 1);
      d  = (t == TDONE);
      cs = (t == 1) || (t >= 2 && t < TDONE && (t - 2) % 64 == 63 && (t - 2) / 64 < NS - 1);
      if (t >= 3) begin
        c = (t - 3) % 64;
        s = (t - 3) / 64;
        dec = pack_dec(s, c < W, c % 16, (s % 2) == 1, (c >= pl) && (c < pl + W),
                       (c - pl + 64) % 16, (s % 2) == 0, (c < W) ? s * 16 + c % 16 : 0);
      end
    end
    return {cs, b, d, dec};
  endfunction

  task automatic check(input string name, input int t, input logic [26:0] got,
                       input logic [26:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
    end
  endtask

  task automatic run_cycle(input logic start);
    @(negedge clk);
    check("cycle", mt, obs_a, expect_out(mt, 20));
    check("cycle_pl47", mt, obs_b, expect_out(mt, 47));
    if (rec) begin
      if (mt >= 0 && mt <= TDONE) snap[mt] = obs_a[23:0];
      n_cs   += int'(cnt_start);
      n_done += int'(done);
    end
    in_start = start;
    if (start && mt < 0)              mt = 1;
    else if (mt >= 1 && mt < TDONE)   mt = mt + 1;
    else if (mt == TDONE)             mt = -1;
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    check("async_reset", mt, obs_a, 27'd0);
    check("async_reset_pl47", mt, obs_b, 27'd0);
    @(negedge clk);
    check("held_reset", mt, obs_a, 27'd0);
    rst = 1'b0;
    in_start = 1'b0;
    mt = -1;
  endtask

  initial begin
    tbl[0] = '{3, 0,  pack_dec(3, 1, 0,  1, 0, 12, 0, 8'h30)};
    tbl[1] = '{3, 15, pack_dec(3, 1, 15, 1, 0, 11, 0, 8'h3F)};
    tbl[2] = '{3, 16, pack_dec(3, 0, 0,  1, 0, 12, 0, 8'h00)};
    tbl[3] = '{3, 20, pack_dec(3, 0, 4,  1, 1, 0,  0, 8'h00)};
    tbl[4] = '{3, 35, pack_dec(3, 0, 3,  1, 1, 15, 0, 8'h00)};
    tbl[5] = '{3, 36, pack_dec(3, 0, 4,  1, 0, 0,  0, 8'h00)};
    tbl[6] = '{0, 5,  pack_dec(0, 1, 5,  0, 0, 1,  1, 8'h05)};
    tbl[7] = '{8, 63, pack_dec(8, 0, 15, 0, 0, 11, 1, 8'h00)};
    tbl[8] = '{8, 10, pack_dec(8, 1, 10, 0, 0, 6,  1, 8'h8A)};
    tbl[9] = '{5, 19, pack_dec(5, 0, 3,  1, 0, 15, 0, 8'h00)};

    repeat (2) @(negedge clk);
    check("reset_state", -1, obs_a, 27'd0);
    rst = 1'b0;

    // Single transform with an ignored start request during stage 4, then back-to-back.
    run_cycle(1'b1);
    rec = 1'b1;
    for (int i = 1; i <= TDONE; i++) run_cycle(i == 2 + 4 * 64 + 10);
    rec = 1'b0;
    check("cnt_start_pulses", 0, 27'(n_cs), 27'(NS));
    check("done_pulses", 0, 27'(n_done), 27'd1);
    for (int i = 0; i < 10; i++)
      check("decode_tbl", 3 + tbl[i].stage * 64 + tbl[i].c,
            {3'b000, snap[3 + tbl[i].stage * 64 + tbl[i].c]}, {3'b000, tbl[i].exp});
    run_cycle(1'b1);
    for (int i = 1; i <= TDONE + 1; i++) run_cycle(1'b0);

    // Reset in stage 5 at count 30, then a fresh transform from stage 0.
    run_cycle(1'b1);
    for (int i = 0; i < 1000 && mt != 2 + 5 * 64 + 30; i++) run_cycle(1'b0);
    if (mt != 2 + 5 * 64 + 30) check("reach_stage5", mt, 27'(mt), 27'(2 + 5 * 64 + 30));
    run_cycle(1'b0);
    async_reset();
    run_cycle(1'b1);
    for (int i = 1; i <= TDONE + 1; i++) run_cycle(1'b0);

    // Randomized gaps, stray start requests and one random reset.
    for (int k = 0; k < 3; k++) begin
      int gap, r;
      gap = $urandom_range(0, 4);
      r   = $urandom_range(3, TDONE - 5);
      for (int g = 0; g < gap; g++) run_cycle(1'b0);
      run_cycle(1'b1);
      for (int i = 0; i < 700; i++) begin
        run_cycle($urandom_range(0, 39) == 0);
        if (k == 1 && mt == r) async_reset();
        if (mt < 0) break;
      end
    end
    run_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
